// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame FSM state encoding and a parity helper
// used by both uart_tx and uart_rx.
package uart_pkg;

   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_PARITY,
      UART_STOP
   } uart_state;

   // Widest data word any frame format supports; narrower words are zero-extended.
   localparam int unsigned UART_MAX_DATA_BITS = 16;

   // Returns the parity bit a transmitter sends for data; odd=1 selects odd parity.
   // A receiver XORs this with the received parity bit to obtain the error flag.
   function automatic logic calc_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                        input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-bit two-flop synchronizer for asynchronous inputs with a selectable
// reset value (1 suits idle-high serial lines).
module uart_sync #(
   parameter int unsigned WIDTH     = 1,
   parameter logic        RESET_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= {WIDTH{RESET_VAL}};
         q    <= {WIDTH{RESET_VAL}};
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples rx at CLK_DIV clocks per bit, samples mid-bit,
// checks parity and stop bits and emits a one-cycle rx_data_valid per frame.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter string       PARITY_BIT = "none",
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned CLK_DIV    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_data_valid,
   output logic                 parity_error,
   output logic                 frame_error
);

   localparam int unsigned BAUD_W = $clog2(CLK_DIV);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

   localparam bit PAR_EN  = (PARITY_BIT != "none");
   localparam bit PAR_ODD = (PARITY_BIT == "odd");

   localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLK_DIV - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_DIV / 2 - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   logic                 rx_s;
   logic                 rx_prev;
   uart_state            state;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err;
   logic                 frm_err;

   uart_sync #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= UART_IDLE;
         rx_prev       <= 1'b1;
         baud_cnt      <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         par_err       <= 1'b0;
         frm_err       <= 1'b0;
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
         parity_error  <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         // rx_prev runs in every state so a line left low after a frame (break or
         // bad stop bit) cannot start a new frame until it has gone high again.
         rx_prev       <= rx_s;
         rx_data_valid <= 1'b0;
         unique case (state)
            UART_IDLE: begin
               if (rx_prev && !rx_s) begin
                  bit_cnt  <= '0;
                  baud_cnt <= BAUD_HALF;
                  state    <= UART_START;
               end
            end
            UART_START: begin
               if (baud_cnt != '0) begin
                  baud_cnt <= baud_cnt - BAUD_W'(1);
               end else if (rx_s) begin
                  state <= UART_IDLE;
               end else begin
                  baud_cnt <= BAUD_FULL;
                  bit_cnt  <= '0;
                  par_err  <= 1'b0;
                  frm_err  <= 1'b0;
                  state    <= UART_DATA;
               end
            end
            UART_DATA: begin
               if (baud_cnt != '0) begin
                  baud_cnt <= baud_cnt - BAUD_W'(1);
               end else begin
                  shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                  baud_cnt <= BAUD_FULL;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= PAR_EN ? UART_PARITY : UART_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            UART_PARITY: begin
               if (baud_cnt != '0) begin
                  baud_cnt <= baud_cnt - BAUD_W'(1);
               end else begin
                  par_err  <= calc_parity(UART_MAX_DATA_BITS'(shreg), PAR_ODD) ^ rx_s;
                  baud_cnt <= BAUD_FULL;
                  bit_cnt  <= '0;
                  state    <= UART_STOP;
               end
            end
            UART_STOP: begin
               if (baud_cnt != '0) begin
                  baud_cnt <= baud_cnt - BAUD_W'(1);
               end else if (bit_cnt == STOP_LAST) begin
                  // Leave mid-stop-bit so an immediately following start edge is seen.
                  rx_data       <= shreg;
                  parity_error  <= PAR_EN && par_err;
                  frame_error   <= frm_err | ~rx_s;
                  rx_data_valid <= 1'b1;
                  bit_cnt       <= '0;
                  state         <= UART_IDLE;
               end else begin
                  frm_err  <= frm_err | ~rx_s;
                  bit_cnt  <= bit_cnt + BIT_W'(1);
                  baud_cnt <= BAUD_FULL;
               end
            end
            default: state <= UART_IDLE;
         endcase
      end
   end

endmodule
